// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: captures a challenge, fires the core NVOTE times and returns the majority bit.
// Result is held on outValid until outReady; reqReady is high only in IDLE; respReady/respBit are synchronized first.
module apuf_eval_ctrl #(
  parameter int CW      = 64,
  parameter int SETTLE  = 4,
  parameter int NVOTE   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reqValid,
  output logic          reqReady,
  input  logic [CW-1:0] reqChal,
  output logic [CW-1:0] c,
  output logic          tigSignal,
  input  logic          respReady,
  input  logic          respBit,
  output logic          outValid,
  input  logic          outReady,
  output logic          outBit,
  output logic [3:0]    outOnes,
  output logic          outTimeout
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic          rdy_meta, rdy_s, bit_meta, bit_s;
  logic [SW-1:0] settle_cnt;
  logic [15:0]   to_cnt;
  logic [3:0]    vote_cnt, ones;
  logic          accept, settle_end, to_end, last_vote;

  assign reqReady   = (state == S_IDLE);
  assign accept     = reqValid && reqReady;
  assign settle_end = (settle_cnt == SW'(SETTLE - 1));
  assign to_end     = (to_cnt == 16'(TIMEOUT - 1));
  assign last_vote  = (vote_cnt == 4'(NVOTE));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_SETTLE;
      S_SETTLE: if (settle_end) state_nxt = S_WAIT;
      S_WAIT: begin
        if (rdy_s)       state_nxt = S_GAP;
        else if (to_end) state_nxt = S_DONE;
      end
      // GAP waits for the arbiter to release before the next firing
      S_GAP: begin
        if (!rdy_s)      state_nxt = last_vote ? S_DONE : S_SETTLE;
        else if (to_end) state_nxt = S_DONE;
      end
      S_DONE:   if (outReady) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rdy_meta   <= 1'b0;
      rdy_s      <= 1'b0;
      bit_meta   <= 1'b0;
      bit_s      <= 1'b0;
      c          <= '0;
      tigSignal  <= 1'b0;
      outValid   <= 1'b0;
      outBit     <= 1'b0;
      outOnes    <= '0;
      outTimeout <= 1'b0;
      settle_cnt <= '0;
      to_cnt     <= '0;
      vote_cnt   <= '0;
      ones       <= '0;
    end else begin
      state    <= state_nxt;
      rdy_meta <= respReady;
      rdy_s    <= rdy_meta;
      bit_meta <= respBit;
      bit_s    <= bit_meta;
      case (state)
        S_IDLE: begin
          if (accept) begin
            c          <= reqChal;
            vote_cnt   <= '0;
            ones       <= '0;
            settle_cnt <= '0;
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + SW'(1);
          if (settle_end) begin
            tigSignal <= 1'b1;
            to_cnt    <= '0;
          end
        end
        S_WAIT: begin
          to_cnt <= to_cnt + 16'd1;
          if (rdy_s) begin
            tigSignal <= 1'b0;
            ones      <= ones + {3'b000, bit_s};
            vote_cnt  <= vote_cnt + 4'd1;
            to_cnt    <= '0;
          end else if (to_end) begin
            tigSignal  <= 1'b0;
            outValid   <= 1'b1;
            outTimeout <= 1'b1;
            outOnes    <= ones;
            outBit     <= 1'b0;
          end
        end
        S_GAP: begin
          to_cnt <= to_cnt + 16'd1;
          if (!rdy_s) begin
            settle_cnt <= '0;
            if (last_vote) begin
              outValid <= 1'b1;
              outOnes  <= ones;
              outBit   <= (ones > 4'(NVOTE / 2));
            end
          end else if (to_end) begin
            outValid   <= 1'b1;
            outTimeout <= 1'b1;
            outOnes    <= ones;
            outBit     <= 1'b0;
          end
        end
        S_DONE: begin
          if (outReady) begin
            outValid   <= 1'b0;
            outTimeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Bench for apuf_eval_ctrl: a behavioural arbiter-core model answers trigger pulses,
// a monitor tracks trigger pulse shapes, and each result is compared with a majority-vote model.
module tb_apuf_eval_ctrl;
  localparam int CW = 64, SETTLE = 4, NVOTE = 5, TIMEOUT = 255;
  localparam int MODE_NORMAL = 0, MODE_NEVER = 1, MODE_STUCK = 2;

  logic          clk = 1'b0, rst = 1'b1;
  logic          reqValid = 1'b0, reqReady;
  logic [CW-1:0] reqChal = '0, c;
  logic          tigSignal, respReady = 1'b0, respBit = 1'b0;
  logic          outValid, outReady = 1'b0, outBit, outTimeout;
  logic [3:0]    outOnes;

  int vectors = 0, miscompares = 0;
  int core_mode = MODE_NORMAL, core_delay = 3, fire_idx = 0, tig_hi = 0;
  logic [15:0] pat = '0;
  int pulses = 0, min_low = 1000, last_hi = 0, low_run = 0, hi_run = 0;
  logic tig_prev = 1'b0;

  always #5 clk = ~clk;

  apuf_eval_ctrl #(.CW(CW), .SETTLE(SETTLE), .NVOTE(NVOTE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqChal(reqChal),
    .c(c), .tigSignal(tigSignal), .respReady(respReady), .respBit(respBit),
    .outValid(outValid), .outReady(outReady), .outBit(outBit), .outOnes(outOnes),
    .outTimeout(outTimeout)
  );

  // Arbiter core model: answers core_delay cycles after the trigger rises, releases when it falls.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (tigSignal === 1'b1) begin
        if (tig_hi == core_delay && core_mode != MODE_NEVER && respReady == 1'b0) begin
          respBit   = pat[fire_idx[3:0]];
          respReady = 1'b1;
          fire_idx++;
        end
        tig_hi++;
      end else begin
        tig_hi = 0;
        if (core_mode != MODE_STUCK) begin
          respReady = 1'b0;
          respBit   = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Trigger monitor: pulse count, shortest low run before a pulse, length of the last pulse.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tigSignal === 1'b1) begin
        if (!tig_prev) begin
          pulses++;
          if (low_run < min_low) min_low = low_run;
          hi_run = 0;
        end
        hi_run++;
        last_hi = hi_run;
      end else begin
        if (tig_prev) low_run = 0;
        low_run++;
      end
      tig_prev = (tigSignal === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #4;
  endtask

  task automatic clear_mon();
    pulses = 0; min_low = 1000; fire_idx = 0;
  endtask

  task automatic send_req(input logic [CW-1:0] chal);
    int n;
    n = 0;
    reqChal = chal; reqValid = 1'b1;
    while (reqReady !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    reqValid = 1'b0;
    reqChal  = {$urandom, $urandom};
  endtask

  task automatic wait_result(input int budget, input string name);
    int n;
    n = 0;
    while (outValid !== 1'b1 && n < budget) begin tick(); n++; end
    vectors++;
    if (outValid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s arrival: outValid=%b after %0d cycles, required 1", name, outValid, n);
    end
  endtask

  task automatic consume();
    outReady = 1'b1; tick(); outReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    vectors++; if (c !== '0) begin miscompares++; $display("FAIL reset_c: got %h, required 0", c); end
    vectors++; if (tigSignal !== 1'b0) begin miscompares++; $display("FAIL reset_tig: got %b, required 0", tigSignal); end
    vectors++; if (outValid !== 1'b0) begin miscompares++; $display("FAIL reset_outValid: got %b, required 0", outValid); end
    vectors++; if (reqReady !== 1'b1) begin miscompares++; $display("FAIL reset_reqReady: got %b, required 1", reqReady); end
    vectors++;
    if (outOnes !== 4'd0 || outBit !== 1'b0 || outTimeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: ones=%0d bit=%b to=%b, required 0 0 0", outOnes, outBit, outTimeout);
    end
  endtask

  task automatic test_nominal();
    logic [CW-1:0] chal;
    int n;
    chal = 64'hA5A5_0F0F_1234_5678;
    core_mode = MODE_NORMAL; core_delay = 3; pat = 16'b01011; clear_mon();
    send_req(chal);
    vectors++; if (c !== chal) begin miscompares++; $display("FAIL nominal_c_capture: got %h, required %h", c, chal); end
    n = 0;
    while (tigSignal !== 1'b1 && n < 50) begin tick(); n++; end
    vectors++; if (n != SETTLE) begin miscompares++; $display("FAIL nominal_tig_rise: after %0d cycles, required %0d", n, SETTLE); end
    wait_result(2000, "nominal");
    vectors++; if (pulses != NVOTE) begin miscompares++; $display("FAIL nominal_pulses: got %0d, required %0d", pulses, NVOTE); end
    vectors++; if (min_low < SETTLE) begin miscompares++; $display("FAIL nominal_settle_low: got %0d, required >= %0d", min_low, SETTLE); end
    vectors++; if (outOnes !== 4'd3) begin miscompares++; $display("FAIL nominal_ones: got %0d, required 3", outOnes); end
    vectors++; if (outBit !== 1'b1) begin miscompares++; $display("FAIL nominal_bit: got %b, required 1", outBit); end
    vectors++; if (outTimeout !== 1'b0) begin miscompares++; $display("FAIL nominal_timeout: got %b, required 0", outTimeout); end
    vectors++; if (c !== chal) begin miscompares++; $display("FAIL nominal_c_hold: got %h, required %h", c, chal); end
  endtask

  task automatic test_backpressure(input logic exp_bit, input logic [3:0] exp_ones);
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (outValid !== 1'b1 || outBit !== exp_bit || outOnes !== exp_ones || outTimeout !== 1'b0 || reqReady !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold cyc %0d: v=%b bit=%b ones=%0d to=%b rdy=%b, required 1 %b %0d 0 0",
                 i, outValid, outBit, outOnes, outTimeout, reqReady, exp_bit, exp_ones);
      end
    end
    consume();
    vectors++; if (outValid !== 1'b0) begin miscompares++; $display("FAIL backpressure_release_valid: got %b, required 0", outValid); end
    vectors++; if (reqReady !== 1'b1) begin miscompares++; $display("FAIL backpressure_release_reqReady: got %b, required 1", reqReady); end
  endtask

  task automatic test_random_votes();
    logic [CW-1:0] chal;
    int   exp_ones;
    logic exp_bit;
    for (int i = 0; i < 6; i++) begin
      chal = {$urandom, $urandom};
      pat = 16'($urandom);
      core_mode = MODE_NORMAL; core_delay = $urandom_range(0, 8); clear_mon();
      exp_ones = $countones(pat[NVOTE-1:0]);
      exp_bit  = (exp_ones * 2 > NVOTE);
      send_req(chal);
      wait_result(3000, "random");
      vectors++; if (outOnes !== 4'(exp_ones)) begin miscompares++; $display("FAIL random_ones #%0d: got %0d, required %0d", i, outOnes, exp_ones); end
      vectors++; if (outBit !== exp_bit) begin miscompares++; $display("FAIL random_bit #%0d: got %b, required %b", i, outBit, exp_bit); end
      vectors++; if (outTimeout !== 1'b0) begin miscompares++; $display("FAIL random_timeout #%0d: got %b, required 0", i, outTimeout); end
      vectors++; if (pulses != NVOTE) begin miscompares++; $display("FAIL random_pulses #%0d: got %0d, required %0d", i, pulses, NVOTE); end
      vectors++; if (c !== chal) begin miscompares++; $display("FAIL random_c #%0d: got %h, required %h", i, c, chal); end
      repeat ($urandom_range(0, 3)) tick();
      consume();
    end
  endtask

  task automatic test_timeout();
    core_mode = MODE_NEVER; respReady = 1'b0; clear_mon();
    send_req({$urandom, $urandom});
    wait_result(600, "timeout");
    vectors++; if (pulses != 1) begin miscompares++; $display("FAIL timeout_pulses: got %0d, required 1", pulses); end
    vectors++; if (last_hi != TIMEOUT) begin miscompares++; $display("FAIL timeout_pulse_len: got %0d, required %0d", last_hi, TIMEOUT); end
    vectors++; if (outTimeout !== 1'b1) begin miscompares++; $display("FAIL timeout_flag: got %b, required 1", outTimeout); end
    vectors++; if (outBit !== 1'b0) begin miscompares++; $display("FAIL timeout_bit: got %b, required 0", outBit); end
    vectors++; if (outOnes !== 4'd0) begin miscompares++; $display("FAIL timeout_ones: got %0d, required 0", outOnes); end
    consume();
    vectors++; if (outTimeout !== 1'b0) begin miscompares++; $display("FAIL timeout_clear: got %b, required 0", outTimeout); end
  endtask

  task automatic test_stuck();
    for (int b = 0; b < 2; b++) begin
      core_mode = MODE_STUCK; core_delay = 3; respReady = 1'b0;
      pat = (b == 1) ? 16'hFFFF : 16'h0000; clear_mon();
      send_req({$urandom, $urandom});
      wait_result(800, "stuck");
      vectors++; if (outTimeout !== 1'b1) begin miscompares++; $display("FAIL stuck_timeout b=%0d: got %b, required 1", b, outTimeout); end
      vectors++; if (outOnes !== 4'(b)) begin miscompares++; $display("FAIL stuck_ones b=%0d: got %0d, required %0d", b, outOnes, b); end
      vectors++; if (outBit !== 1'b0) begin miscompares++; $display("FAIL stuck_bit b=%0d: got %b, required 0", b, outBit); end
      vectors++; if (pulses != 1) begin miscompares++; $display("FAIL stuck_pulses b=%0d: got %0d, required 1", b, pulses); end
      core_mode = MODE_NORMAL; respReady = 1'b0;
      consume();
      repeat (4) tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    int   n, exp_ones;
    logic [CW-1:0] chal;
    core_mode = MODE_NEVER; respReady = 1'b0; clear_mon();
    send_req({$urandom, $urandom});
    n = 0;
    while (tigSignal !== 1'b1 && n < 50) begin tick(); n++; end
    repeat ($urandom_range(0, 20)) tick();
    vectors++; if (tigSignal !== 1'b1) begin miscompares++; $display("FAIL midwait_pre_tig: got %b, required 1", tigSignal); end
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++; if (tigSignal !== 1'b0) begin miscompares++; $display("FAIL midwait_tig: got %b, required 0", tigSignal); end
    vectors++; if (c !== '0) begin miscompares++; $display("FAIL midwait_c: got %h, required 0", c); end
    vectors++; if (reqReady !== 1'b1) begin miscompares++; $display("FAIL midwait_reqReady: got %b, required 1", reqReady); end
    vectors++; if (outValid !== 1'b0) begin miscompares++; $display("FAIL midwait_outValid: got %b, required 0", outValid); end
    chal = {$urandom, $urandom};
    pat = 16'($urandom); core_mode = MODE_NORMAL; core_delay = 2; clear_mon();
    exp_ones = $countones(pat[NVOTE-1:0]);
    send_req(chal);
    wait_result(2000, "after_reset");
    vectors++; if (outOnes !== 4'(exp_ones)) begin miscompares++; $display("FAIL after_reset_ones: got %0d, required %0d", outOnes, exp_ones); end
    vectors++; if (outBit !== (exp_ones * 2 > NVOTE)) begin miscompares++; $display("FAIL after_reset_bit: got %b, required %b", outBit, exp_ones * 2 > NVOTE); end
    vectors++; if (outTimeout !== 1'b0) begin miscompares++; $display("FAIL after_reset_timeout: got %b, required 0", outTimeout); end
    vectors++; if (c !== chal) begin miscompares++; $display("FAIL after_reset_c: got %h, required %h", c, chal); end
    consume();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure(1'b1, 4'd3);
    test_random_votes();
    test_timeout();
    test_stuck();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
